// File: rtl/lifo_stack_ext.sv
// Parametrised LIFO stack: visible top, occupancy count, registered pop data, atomic replace-top.
// Optional sticky overflow/underflow flags are enabled by defining STACK_ERR_EN.
module lifo_stack_ext #(
  parameter int WIDTH_DATA = 32,
  parameter int DEPTH      = 16,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH_DATA-1:0] data_in,
  input  logic                  err_clr,
  output logic [WIDTH_DATA-1:0] data_out,
  output logic                  pop_valid,
  output logic [WIDTH_DATA-1:0] top,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [WIDTH_DATA-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]       r_count;
  logic [WIDTH_DATA-1:0] r_data_out;
  logic                  r_pop_valid;

  logic [ADDR_W-1:0] w_top_idx;
  logic [ADDR_W-1:0] w_wr_idx;
  logic              w_full;
  logic              w_empty;
  logic              w_grow;
  logic              w_shrink;
  logic              w_replace;
  logic              w_pop_acc;

  assign w_full    = (r_count == C_DEPTH);
  assign w_empty   = (r_count == '0);
  // Low bits of count wrap to the right slot even when count == DEPTH.
  assign w_top_idx = r_count[ADDR_W-1:0] - ADDR_W'(1);

  assign w_replace = push & pop & !w_empty;
  assign w_grow    = push & !w_full & (!pop | w_empty);
  assign w_shrink  = pop & !push & !w_empty;
  assign w_pop_acc = pop & !w_empty;
  assign w_wr_idx  = w_replace ? w_top_idx : r_count[ADDR_W-1:0];

  // Storage is deliberately not reset; only pointer and outputs are.
  always_ff @(posedge clk) begin
    if (!reset && (w_grow || w_replace)) begin
      r_mem[w_wr_idx] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_data_out  <= '0;
      r_pop_valid <= 1'b0;
    end else begin
      r_pop_valid <= w_pop_acc;
      if (w_pop_acc) begin
        r_data_out <= r_mem[w_top_idx];
      end
      if (w_grow) begin
        r_count <= r_count + 1'b1;
      end else if (w_shrink) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

`ifdef STACK_ERR_EN
  logic r_overflow;
  logic r_underflow;
  logic w_ovf_set;
  logic w_unf_set;

  assign w_ovf_set = push & !pop & w_full;
  assign w_unf_set = pop & w_empty;

  // A new error in the same cycle as err_clr leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set | (r_overflow  & !err_clr);
      r_underflow <= w_unf_set | (r_underflow & !err_clr);
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

  assign data_out  = r_data_out;
  assign pop_valid = r_pop_valid;
  assign top       = r_mem[w_top_idx];
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;

endmodule

// File: tb/tb_lifo_stack_ext.sv
// Self-checking bench for lifo_stack_ext (WIDTH_DATA=8, DEPTH=4) against a queue-based stack model.
// Flag expectations follow STACK_ERR_EN when the bench is built with it.
module tb_lifo_stack_ext;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset, push, pop, err_clr;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out, top;
  logic         pop_valid, full, empty, overflow, underflow;
  logic [2:0]   count;

  lifo_stack_ext #(.WIDTH_DATA(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .err_clr(err_clr), .data_out(data_out), .pop_valid(pop_valid), .top(top),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue whose last element is the top of stack.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_dout;
  logic         m_pv, m_ovf, m_unf;
  logic         e_ovf, e_unf;

  // One clock: apply inputs, advance the model, settle 1 time unit past the edge.
  task automatic drive(input logic r, input logic pu, input logic po,
                       input logic [W-1:0] d, input logic clr);
    logic set_o, set_u;
    reset = r; push = pu; pop = po; data_in = d; err_clr = clr;
    @(posedge clk);
    set_o = 1'b0; set_u = 1'b0;
    if (r) begin
      m_q.delete();
      m_dout = '0; m_pv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      m_pv = 1'b0;
      if (pu && po) begin
        if (m_q.size() > 0) begin
          m_dout = m_q[m_q.size()-1];
          m_pv = 1'b1;
          m_q[m_q.size()-1] = d;
        end else begin
          m_q.push_back(d);
          set_u = 1'b1;
        end
      end else if (pu) begin
        if (m_q.size() < D) m_q.push_back(d);
        else set_o = 1'b1;
      end else if (po) begin
        if (m_q.size() > 0) begin
          m_dout = m_q.pop_back();
          m_pv = 1'b1;
        end else set_u = 1'b1;
      end
      m_ovf = set_o | (m_ovf & !clr);
      m_unf = set_u | (m_unf & !clr);
    end
`ifdef STACK_ERR_EN
    e_ovf = m_ovf; e_unf = m_unf;
`else
    e_ovf = 1'b0;  e_unf = 1'b0;
`endif
    #1;
    reset = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 8'h00, 0);
    n_checks += 5;
    if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_empty_full got %b%b exp 10", empty, full); end
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %0h exp 0", data_out); end
    if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pv got %b exp 0", pop_valid); end
    if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b%b exp 00", overflow, underflow); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 0, W'(i), 0);
      n_checks++;
      if (count !== 3'(i)) begin n_fail++; $display("FAIL fill_count got %0d exp %0d", count, i); end
    end
    n_checks += 3;
    if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b exp 1", full); end
    if (top !== 8'd4) begin n_fail++; $display("FAIL fill_top got %0d exp 4", top); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_overflow();
    drive(0, 1, 0, 8'd9, 0);
    n_checks += 3;
    if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d exp 4", count); end
    if (top !== 8'd4) begin n_fail++; $display("FAIL ovf_top got %0d exp 4", top); end
    if (overflow !== e_ovf) begin n_fail++; $display("FAIL ovf_set got %b exp %b", overflow, e_ovf); end
    drive(0, 0, 0, 8'd0, 0);
    n_checks++;
    if (overflow !== e_ovf) begin n_fail++; $display("FAIL ovf_sticky got %b exp %b", overflow, e_ovf); end
    drive(0, 0, 0, 8'd0, 1);
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b exp 0", overflow); end
  endtask

  task automatic test_drain();
    for (int i = 4; i >= 1; i--) begin
      drive(0, 0, 1, 8'd0, 0);
      n_checks += 2;
      if (data_out !== W'(i)) begin n_fail++; $display("FAIL drain_dout got %0d exp %0d", data_out, i); end
      if (pop_valid !== 1'b1) begin n_fail++; $display("FAIL drain_pv got %b exp 1", pop_valid); end
    end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b exp 1", empty); end
    drive(0, 0, 1, 8'd0, 0);
    n_checks += 3;
    if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL unf_pv got %b exp 0", pop_valid); end
    if (data_out !== 8'd1) begin n_fail++; $display("FAIL unf_dout got %0d exp 1", data_out); end
    if (underflow !== e_unf) begin n_fail++; $display("FAIL unf_set got %b exp %b", underflow, e_unf); end
  endtask

  task automatic test_replace();
    drive(0, 0, 0, 8'd0, 1);
    drive(0, 1, 0, 8'd5, 0);
    drive(0, 1, 0, 8'd6, 0);
    drive(0, 1, 1, 8'd7, 0);
    n_checks += 4;
    if (data_out !== 8'd6) begin n_fail++; $display("FAIL repl_dout got %0d exp 6", data_out); end
    if (pop_valid !== 1'b1) begin n_fail++; $display("FAIL repl_pv got %b exp 1", pop_valid); end
    if (count !== 3'd2) begin n_fail++; $display("FAIL repl_count got %0d exp 2", count); end
    if (top !== 8'd7) begin n_fail++; $display("FAIL repl_top got %0d exp 7", top); end
    drive(0, 0, 0, 8'd0, 0);
    n_checks++;
    if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL repl_pv_pulse got %b exp 0", pop_valid); end
  endtask

  task automatic test_empty_pushpop();
    drive(0, 0, 1, 8'd0, 0);
    drive(0, 0, 1, 8'd0, 1);
    drive(0, 1, 1, 8'd3, 0);
    n_checks += 4;
    if (count !== 3'd1) begin n_fail++; $display("FAIL epp_count got %0d exp 1", count); end
    if (top !== 8'd3) begin n_fail++; $display("FAIL epp_top got %0d exp 3", top); end
    if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL epp_pv got %b exp 0", pop_valid); end
    if (underflow !== e_unf) begin n_fail++; $display("FAIL epp_unf got %b exp %b", underflow, e_unf); end
  endtask

  task automatic test_set_wins();
    drive(0, 0, 1, 8'd0, 0);
    drive(0, 0, 1, 8'd0, 1);
    n_checks++;
    if (underflow !== e_unf) begin n_fail++; $display("FAIL setwins_unf got %b exp %b", underflow, e_unf); end
  endtask

  task automatic test_reset_during_push();
    drive(0, 1, 0, 8'd11, 0);
    drive(0, 1, 0, 8'd12, 0);
    drive(0, 1, 0, 8'd13, 0);
    drive(0, 0, 1, 8'd0, 0);
    drive(0, 1, 0, 8'd13, 0);
    drive(0, 1, 1, 8'd14, 0);
    n_checks++;
    if (count !== 3'd3) begin n_fail++; $display("FAIL rdp_pre_count got %0d exp 3", count); end
    drive(1, 1, 0, 8'd55, 1);
    n_checks += 4;
    if (count !== 3'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL rdp_count got %0d/%b exp 0/1", count, empty); end
    if (data_out !== 8'd0) begin n_fail++; $display("FAIL rdp_dout got %0h exp 0", data_out); end
    if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL rdp_pv got %b exp 0", pop_valid); end
    if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL rdp_flags got %b%b exp 00", overflow, underflow); end
  endtask

  task automatic test_random();
    logic [W-1:0] e_top;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            W'($urandom), $urandom_range(0, 7) == 0);
      n_checks++;
      if (count !== 3'(m_q.size()) || full !== (m_q.size() == D) || empty !== (m_q.size() == 0)
          || data_out !== m_dout || pop_valid !== m_pv
          || overflow !== e_ovf || underflow !== e_unf) begin
        n_fail++;
        $display("FAIL rand_%0d got cnt=%0d f=%b e=%b do=%0h pv=%b ov=%b un=%b exp cnt=%0d do=%0h pv=%b ov=%b un=%b",
                 i, count, full, empty, data_out, pop_valid, overflow, underflow,
                 m_q.size(), m_dout, m_pv, e_ovf, e_unf);
      end
      if (m_q.size() > 0) begin
        e_top = m_q[m_q.size()-1];
        n_checks++;
        if (top !== e_top) begin n_fail++; $display("FAIL rand_top_%0d got %0h exp %0h", i, top, e_top); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; data_in = '0;
    m_dout = '0; m_pv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_replace();
    test_empty_pushpop();
    test_set_wins();
    test_reset_during_push();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
